// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose:
//   Shares one purely combinational 16-bit 74181-style ALU between N_REQ
//   requesters (2..4).
//   - A round-robin arbiter picks one pending operation while idle.
//   - The winner's operation is registered and presented to the ALU for
//     exactly one cycle.
//   - The ALU result is captured and returned on a valid/ready response
//     channel.
//   - Only one operation is in flight at a time: IDLE -> EXEC -> RESP.
//
// Parameters:
//   N_REQ          number of requesters, 2..4 (anything else fails elaboration)
//
// Ports:
//   clk            clock, all state on the rising edge
//   rst            synchronous active-high reset
//   req_valid      [N_REQ]     requester i has an operation pending
//   req_ready      [N_REQ]     one-hot grant (combinational, only in IDLE)
//   req_s          [4*N_REQ]   ALU select per requester, bits [4i+3:4i]
//   req_ci         [N_REQ]     carry-in per requester
//   req_m          [N_REQ]     mode per requester (1 = logic, 0 = arithmetic)
//   req_a, req_b   [16*N_REQ]  operands per requester, bits [16i+15:16i]
//   alu_s/ci/m/a/b             registered operation driven into the ALU
//   alu_y          [16]        ALU result, combinational from alu_*
//   rsp_valid      result available
//   rsp_ready      consumer accepts the result
//   rsp_data       [16]        captured ALU result
//   rsp_id         [2]         index of the requester that issued the op
//   rsp_zero       (only with ALU_ZERO_FLAG_EN) captured result == 0
//   busy           high whenever the FSM is not in IDLE
//
// Optional feature macro: ALU_ZERO_FLAG_EN adds the rsp_zero output.
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [4*N_REQ-1:0]    req_s,
    input  logic [N_REQ-1:0]      req_ci,
    input  logic [N_REQ-1:0]      req_m,
    input  logic [16*N_REQ-1:0]   req_a,
    input  logic [16*N_REQ-1:0]   req_b,
    output logic [3:0]            alu_s,
    output logic                  alu_ci,
    output logic                  alu_m,
    output logic [15:0]           alu_a,
    output logic [15:0]           alu_b,
    input  logic [15:0]           alu_y,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [15:0]           rsp_data,
    output logic [1:0]            rsp_id,
`ifdef ALU_ZERO_FLAG_EN
    output logic                  rsp_zero,
`endif
    output logic                  busy
);

    generate
        if (N_REQ < 2 || N_REQ > 4) begin : g_bad_n_req
            $error("alu_share_arbiter: N_REQ must be 2..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic [1:0]        last_q;
    logic [3:0]        alu_s_q;
    logic              alu_ci_q;
    logic              alu_m_q;
    logic [15:0]       alu_a_q;
    logic [15:0]       alu_b_q;
    logic              rsp_valid_q;
    logic [15:0]       rsp_data_q;
    logic [1:0]        rsp_id_q;
`ifdef ALU_ZERO_FLAG_EN
    logic              rsp_zero_q;
`endif

    // Round-robin search results and the winner's operation fields
    logic [N_REQ-1:0]  grant_d;
    logic              grant_any_d;
    logic [1:0]        grant_idx_d;
    logic [3:0]        sel_s_d;
    logic              sel_ci_d;
    logic              sel_m_d;
    logic [15:0]       sel_a_d;
    logic [15:0]       sel_b_d;

    // Search starts one past the last winner and wraps. The inner loop
    // compares against a constant requester index so every select below
    // is a constant part-select after unrolling.
    always_comb begin
        grant_d     = '0;
        grant_any_d = 1'b0;
        grant_idx_d = '0;
        sel_s_d     = '0;
        sel_ci_d    = 1'b0;
        sel_m_d     = 1'b0;
        sel_a_d     = '0;
        sel_b_d     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!grant_any_d && req_valid[i] &&
                    (i == ((int'(last_q) + k) % N_REQ))) begin
                    grant_any_d = 1'b1;
                    grant_d[i]  = 1'b1;
                    grant_idx_d = 2'(i);
                    sel_s_d     = req_s[4*i +: 4];
                    sel_ci_d    = req_ci[i];
                    sel_m_d     = req_m[i];
                    sel_a_d     = req_a[16*i +: 16];
                    sel_b_d     = req_b[16*i +: 16];
                end
            end
        end
    end

    // Grants are only offered while idle, and never while reset is applied.
    assign req_ready = (state_q == IDLE && !rst) ? grant_d : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 2'(N_REQ - 1);
            alu_s_q     <= '0;
            alu_ci_q    <= 1'b0;
            alu_m_q     <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
`ifdef ALU_ZERO_FLAG_EN
            rsp_zero_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_any_d) begin
                        alu_s_q  <= sel_s_d;
                        alu_ci_q <= sel_ci_d;
                        alu_m_q  <= sel_m_d;
                        alu_a_q  <= sel_a_d;
                        alu_b_q  <= sel_b_d;
                        rsp_id_q <= grant_idx_d;
                        last_q   <= grant_idx_d;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU inputs have been stable for the whole cycle.
                    rsp_data_q  <= alu_y;
`ifdef ALU_ZERO_FLAG_EN
                    rsp_zero_q  <= (alu_y == 16'h0000);
`endif
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alu_s     = alu_s_q;
    assign alu_ci    = alu_ci_q;
    assign alu_m     = alu_m_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
`ifdef ALU_ZERO_FLAG_EN
    assign rsp_zero  = rsp_zero_q;
`endif
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Purpose:
//   Self-checking bench for alu_share_arbiter with N_REQ = 4.
//   - The ALU is a stub: y = a + b mod 2^16.
//   - Directed checks: a vector table plus hand-written sequences for reset,
//     fairness, backpressure, reset mid-operation and a withdrawn request.
//   - Random phase: stimulus is compared cycle by cycle against a
//     transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [4*NR-1:0]   req_s;
    logic [NR-1:0]     req_ci;
    logic [NR-1:0]     req_m;
    logic [16*NR-1:0]  req_a;
    logic [16*NR-1:0]  req_b;
    logic [3:0]        alu_s;
    logic              alu_ci;
    logic              alu_m;
    logic [15:0]       alu_a;
    logic [15:0]       alu_b;
    logic [15:0]       alu_y;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_data;
    logic [1:0]        rsp_id;
`ifdef ALU_ZERO_FLAG_EN
    logic              rsp_zero;
`endif
    logic              busy;

    int nchk = 0;
    int nerr = 0;
    int cycle_no = 0;

    assign alu_y = alu_a + alu_b;

    alu_share_arbiter #(.N_REQ(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_s     (req_s),
        .req_ci    (req_ci),
        .req_m     (req_m),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_s     (alu_s),
        .alu_ci    (alu_ci),
        .alu_m     (alu_m),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_y     (alu_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
`ifdef ALU_ZERO_FLAG_EN
        .rsp_zero  (rsp_zero),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [3:0]  s;
        logic        ci;
        logic        m;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
    } vec_t;

    vec_t vecs[7];

    task automatic cyc();
        @(posedge clk);
        #1;
        cycle_no++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle_no);
        end
    endtask

    task automatic set_op(input int i, input logic [3:0] s, input logic ci, input logic m,
                          input logic [15:0] a, input logic [15:0] b);
        req_s[4*i +: 4]   = s;
        req_ci[i]         = ci;
        req_m[i]          = m;
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        cyc();
        rst       = 1'b0;
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference arbitration rule: first valid requester after ptr, with wrap.
    function automatic int rr_pick(input int ptr, input logic [3:0] v);
        for (int k = 1; k <= NR; k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_alu_s"},     32'(alu_s),     32'd0);
        chk({tag, "_alu_ci"},    32'(alu_ci),    32'd0);
        chk({tag, "_alu_m"},     32'(alu_m),     32'd0);
        chk({tag, "_alu_a"},     32'(alu_a),     32'd0);
        chk({tag, "_alu_b"},     32'(alu_b),     32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
        chk({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
`ifdef ALU_ZERO_FLAG_EN
        chk({tag, "_rsp_zero"},  32'(rsp_zero),  32'd0);
`endif
    endtask

    task automatic run_vec(input vec_t v);
        bit got = 1'b0;
        set_op(v.id, v.s, v.ci, v.m, v.a, v.b);
        req_valid = 4'(1 << v.id);
        rsp_ready = 1'b0;
        for (int w = 0; w < 8 && !got; w++) begin
            #1;
            if (req_ready[v.id]) got = 1'b1;
            else cyc();
        end
        chk("vec_grant_seen", 32'(got), 32'd1);
        if (!got) begin
            do_reset();
            return;
        end
        chk("vec_ready_onehot", 32'(req_ready), 32'(1 << v.id));
        cyc();
        req_valid = '0;
        chk("vec_alu_s",  32'(alu_s),  32'(v.s));
        chk("vec_alu_ci", 32'(alu_ci), 32'(v.ci));
        chk("vec_alu_m",  32'(alu_m),  32'(v.m));
        chk("vec_alu_a",  32'(alu_a),  32'(v.a));
        chk("vec_alu_b",  32'(alu_b),  32'(v.b));
        chk("vec_busy_exec", 32'(busy), 32'd1);
        cyc();
        chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("vec_rsp_data",  32'(rsp_data),  32'(v.y));
        chk("vec_rsp_id",    32'(rsp_id),    32'(v.id));
`ifdef ALU_ZERO_FLAG_EN
        chk("vec_rsp_zero",  32'(rsp_zero),  32'(v.y == 16'h0000));
`endif
        $display("vec id=%0d a=%h b=%h rsp_data=%h rsp_id=%0d", v.id, v.a, v.b, rsp_data, rsp_id);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        chk("vec_rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int ids[$];
        int at[$];
        int exp_ord[6];
        bit   m_free;
        int   m_ptr, m_age, m_id, pick;
        logic [15:0] m_data;
        logic [3:0]  exp_rdy;
        bit   exp_rv;

        exp_ord = '{0, 1, 2, 3, 0, 1};
        vecs[0] = '{0, 4'h9, 1'b0, 1'b0, 16'h0003, 16'h0004, 16'h0007};
        vecs[1] = '{1, 4'h6, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000};
        vecs[2] = '{2, 4'hB, 1'b0, 1'b1, 16'h0001, 16'h0001, 16'h0002};
        vecs[3] = '{3, 4'h9, 1'b1, 1'b0, 16'h1234, 16'h4321, 16'h5555};
        vecs[4] = '{0, 4'hF, 1'b1, 1'b1, 16'h8000, 16'h8000, 16'h0000};
        vecs[5] = '{3, 4'h3, 1'b0, 1'b1, 16'h00FF, 16'hFF01, 16'h0000};
        vecs[6] = '{2, 4'hA, 1'b1, 1'b0, 16'h7FFF, 16'h0001, 16'h8000};

        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        req_s = '0; req_ci = '0; req_m = '0; req_a = '0; req_b = '0;

        // ---- Reset state, grant gated by rst, then a single request ----
        cyc();
        req_valid = 4'hF;
        #1;
        chk("rst_ready_gated", 32'(req_ready), 32'd0);
        check_zero_outputs("rst");
        rst = 1'b0;
        req_valid = 4'b0001;
        set_op(0, 4'h9, 1'b0, 1'b0, 16'h0003, 16'h0004);
        #1;
        chk("single_grant", 32'(req_ready), 32'b0001);
        cyc();
        req_valid = '0;
        chk("single_alu_s", 32'(alu_s), 32'h9);
        chk("single_alu_a", 32'(alu_a), 32'h3);
        chk("single_busy_t1", 32'(busy), 32'd1);
        chk("single_rv_t1", 32'(rsp_valid), 32'd0);
        cyc();
        chk("single_rv_t2", 32'(rsp_valid), 32'd1);
        chk("single_data", 32'(rsp_data), 32'h0007);
        chk("single_id", 32'(rsp_id), 32'd0);
        chk("single_busy_t2", 32'(busy), 32'd1);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        chk("single_idle_busy", 32'(busy), 32'd0);

        // ---- Vector table ----
        foreach (vecs[i]) run_vec(vecs[i]);

        // ---- Fairness with all requesters asserted ----
        do_reset();
        for (int i = 0; i < NR; i++) set_op(i, 4'(i), 1'b0, 1'b0, 16'(i * 16'h0101), 16'h0010);
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int w = 0; w < 40 && ids.size() < 6; w++) begin
            #1;
            if ((req_valid & req_ready) != 0) begin
                chk("fair_onehot", 32'($countones(req_ready)), 32'd1);
                ids.push_back(onehot_idx(req_ready));
                at.push_back(cycle_no);
            end
            cyc();
        end
        chk("fair_count", 32'(ids.size()), 32'd6);
        for (int k = 0; k < ids.size(); k++) begin
            chk("fair_order", 32'(ids[k]), 32'(exp_ord[k]));
            if (k > 0) chk("fair_spacing", 32'(at[k] - at[k-1]), 32'd3);
        end
        $display("fairness grants=%0d", ids.size());
        do_reset();

        // ---- Backpressure ----
        set_op(0, 4'h1, 1'b0, 1'b0, 16'h0100, 16'h0023);
        set_op(1, 4'h2, 1'b0, 1'b0, 16'h0200, 16'h0002);
        req_valid = 4'b0001;
        #1;
        chk("bp_grant0", 32'(req_ready), 32'b0001);
        cyc();
        req_valid = 4'b0010;
        cyc();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", 32'(rsp_data), 32'h0123);
            chk("bp_rsp_id", 32'(rsp_id), 32'd0);
            chk("bp_ready_zero", 32'(req_ready), 32'd0);
            cyc();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_hs_valid", 32'(rsp_valid), 32'd1);
        cyc();
        rsp_ready = 1'b0;
        #1;
        chk("bp_grant1", 32'(req_ready), 32'b0010);
        cyc();
        req_valid = '0;
        cyc();
        chk("bp_rsp1_id", 32'(rsp_id), 32'd1);
        chk("bp_rsp1_data", 32'(rsp_data), 32'h0202);
        $display("backpressure rsp_id=%0d rsp_data=%h", rsp_id, rsp_data);
        do_reset();

        // ---- Reset during EXEC, then during RESP ----
        for (int ph = 0; ph < 2; ph++) begin
            set_op(0, 4'h5, 1'b1, 1'b1, 16'h1111, 16'h2222);
            set_op(1, 4'h6, 1'b0, 1'b0, 16'h3333, 16'h0001);
            req_valid = 4'b0001;
            #1;
            chk("rmid_grant0", 32'(req_ready), 32'b0001);
            cyc();
            req_valid = '0;
            if (ph == 1) cyc();
            rst = 1'b1;
            cyc();
            rst = 1'b0;
            check_zero_outputs(ph == 0 ? "rexec" : "rresp");
            req_valid = 4'b0011;
            #1;
            chk("rmid_next_grant", 32'(req_ready), 32'b0001);
            $display("reset-mid phase=%0d next grant=%b", ph, req_ready);
            do_reset();
        end

        // ---- Withdrawn request while in RESP ----
        set_op(0, 4'h0, 1'b0, 1'b0, 16'h0005, 16'h0005);
        set_op(1, 4'h0, 1'b0, 1'b0, 16'h0009, 16'h0009);
        req_valid = 4'b0001;
        #1;
        chk("wd_grant0", 32'(req_ready), 32'b0001);
        cyc();
        req_valid = '0;
        cyc();
        req_valid = 4'b0010;
        #1;
        chk("wd_resp_ready_zero", 32'(req_ready), 32'd0);
        cyc();
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        chk("wd_rsp_data", 32'(rsp_data), 32'h000A);
        cyc();
        rsp_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("wd_no_grant", 32'(req_ready), 32'd0);
            chk("wd_no_rsp", 32'(rsp_valid), 32'd0);
            chk("wd_idle", 32'(busy), 32'd0);
            cyc();
        end
        $display("withdrawn request: no grant, no response");

        // ---- Randomized run against transaction-level model ----
        do_reset();
        m_free = 1'b1; m_ptr = NR - 1; m_age = 0; m_id = 0; m_data = '0;
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < NR; i++)
                set_op(i, 4'($urandom), 1'($urandom), 1'($urandom),
                       16'($urandom), ($urandom_range(0, 7) == 0) ? 16'(-int'(req_a[16*i +: 16])) : 16'($urandom));
            req_valid = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            rsp_ready = ($urandom_range(0, 2) != 0);
            #1;
            pick    = rr_pick(m_ptr, req_valid);
            exp_rdy = (m_free && pick >= 0) ? 4'(1 << pick) : 4'h0;
            exp_rv  = !m_free && (m_age >= 2);
            chk("rand_req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("rand_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            chk("rand_busy", 32'(busy), 32'(!m_free));
            if (exp_rv) begin
                chk("rand_rsp_data", 32'(rsp_data), 32'(m_data));
                chk("rand_rsp_id", 32'(rsp_id), 32'(m_id));
`ifdef ALU_ZERO_FLAG_EN
                chk("rand_rsp_zero", 32'(rsp_zero), 32'(m_data == 16'h0000));
`endif
            end
            if (m_free) begin
                if (pick >= 0) begin
                    m_free = 1'b0;
                    m_age  = 1;
                    m_ptr  = pick;
                    m_id   = pick;
                    m_data = req_a[16*pick +: 16] + req_b[16*pick +: 16];
                end
            end else if (m_age >= 2) begin
                if (rsp_ready) begin
                    m_free = 1'b1;
                    $display("rand txn id=%0d data=%h", m_id, m_data);
                end
            end else begin
                m_age++;
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
